// File: rtl/cam_seq_pkg.sv
//==============================================================================
// Module   : cam_seq_pkg
// Brief    : Shared state encoding and reset values for the camera frame
//            sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package cam_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_WAIT_VS = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } seq_state_t;

  localparam seq_state_t c_state_init      = ST_IDLE;
  localparam logic       c_rstn_init       = 1'b1;
  localparam logic       c_acc_enable_init = 1'b0;
  localparam logic       c_acc_clear_init  = 1'b0;
  localparam logic       c_busy_init       = 1'b0;
  localparam logic       c_frame_done_init = 1'b0;
  localparam logic       c_timeout_init    = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cam_vsync_sync.sv
//==============================================================================
// Module   : cam_vsync_sync
// Brief    : Two-flop synchroniser for the camera vsync pin followed by a
//            registered rising-edge detector.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cam_vsync_sync (
  input  logic sys_clock,
  input  logic reset,
  input  logic cmos_vsync,
  output logic vs_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_vs_rise;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_sync_d  <= 1'b0;
      r_vs_rise <= 1'b0;
    end else begin
      r_meta    <= cmos_vsync;
      r_sync    <= r_meta;
      r_sync_d  <= r_sync;
      r_vs_rise <= r_sync & ~r_sync_d;
    end
  end

  assign vs_rise = r_vs_rise;

endmodule

`default_nettype wire

// File: rtl/cam_frame_sequencer.sv
//==============================================================================
// Module   : cam_frame_sequencer
// Brief    : Sequences datapath soft resets and accelerator enable/clear
//            around camera frame boundaries.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cam_frame_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int DRAIN_CYCLES   = 256,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int FCNT_W         = 16
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic [FCNT_W-1:0] num_frames,
  input  logic              cmos_vsync,
  output logic              fifo_rstn,
  output logic              dma_rstn,
  output logic              acc_rstn,
  output logic              acc_enable,
  output logic              acc_clear,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              timeout_err
);

  import cam_seq_pkg::*;

  localparam int c_cnt_max = max3(RST_CYCLES, DRAIN_CYCLES, TIMEOUT_CYCLES);
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_rst_load    = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_drain_load  = c_cnt_w'(DRAIN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_wait_load   = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [FCNT_W:0]    c_fcnt_one    = (FCNT_W+1)'(1);

  logic w_vs_rise;

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [FCNT_W-1:0]   r_num_frames;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic                r_stop_pending;
  logic                w_stop_pending_nxt;
  logic                r_last_frame;
  logic                w_start;
  logic                w_timeout_set;

  logic                r_rstn;
  logic                r_acc_enable;
  logic                r_acc_clear;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_timeout_err;
  logic                w_rstn_nxt;
  logic                w_acc_enable_nxt;
  logic                w_acc_clear_nxt;
  logic                w_busy_nxt;
  logic                w_frame_done_nxt;

  cam_vsync_sync u_vsync_sync (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .cmos_vsync (cmos_vsync),
    .vs_rise    (w_vs_rise)
  );

  // State, counters and registered outputs share one register process.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_state        <= c_state_init;
      r_cnt          <= '0;
      r_num_frames   <= '0;
      r_frame_cnt    <= '0;
      r_stop_pending <= 1'b0;
      r_last_frame   <= 1'b0;
      r_rstn         <= c_rstn_init;
      r_acc_enable   <= c_acc_enable_init;
      r_acc_clear    <= c_acc_clear_init;
      r_busy         <= c_busy_init;
      r_frame_done   <= c_frame_done_init;
      r_timeout_err  <= c_timeout_init;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_stop_pending <= w_stop_pending_nxt;
      r_rstn         <= w_rstn_nxt;
      r_acc_enable   <= w_acc_enable_nxt;
      r_acc_clear    <= w_acc_clear_nxt;
      r_busy         <= w_busy_nxt;
      r_frame_done   <= w_frame_done_nxt;

      if (w_start) begin
        r_num_frames  <= num_frames;
        r_frame_cnt   <= '0;
        r_timeout_err <= 1'b0;
        r_last_frame  <= 1'b0;
      end else begin
        if (w_timeout_set) begin
          r_timeout_err <= 1'b1;
        end
        if (w_frame_done_nxt) begin
          // Decide "last frame" against the pre-increment count so that
          // saturation cannot make a limited run look finished early.
          r_last_frame <= (r_num_frames != '0) &&
                          (({1'b0, r_frame_cnt} + c_fcnt_one) == {1'b0, r_num_frames});
          if (r_frame_cnt != '1) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_stop_pending_nxt = r_stop_pending;
    w_start            = 1'b0;
    w_timeout_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start) begin
          w_state_nxt        = ST_RESET;
          w_cnt_nxt          = c_rst_load;
          w_stop_pending_nxt = 1'b0;
          w_start            = 1'b1;
        end
      end
      ST_RESET: begin
        if (cmd_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_WAIT_VS;
          w_cnt_nxt   = c_wait_load;
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      ST_WAIT_VS: begin
        if (cmd_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vs_rise) begin
          w_state_nxt = ST_CAPTURE;
        end else if (r_cnt == '0) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_set = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      ST_CAPTURE: begin
        if (cmd_stop) begin
          w_stop_pending_nxt = 1'b1;
        end
        if (w_vs_rise) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = c_drain_load;
        end
      end
      ST_DRAIN: begin
        if (cmd_stop) begin
          w_stop_pending_nxt = 1'b1;
        end
        if (r_cnt == '0) begin
          if (r_stop_pending || cmd_stop || r_last_frame) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_VS;
            w_cnt_nxt   = c_wait_load;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the state they describe.
  always_comb begin
    w_rstn_nxt       = (w_state_nxt != ST_RESET);
    w_acc_enable_nxt = (w_state_nxt == ST_CAPTURE);
    w_acc_clear_nxt  = (r_state == ST_WAIT_VS) && (w_state_nxt == ST_CAPTURE);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_frame_done_nxt = (w_state_nxt == ST_DRAIN) && (w_cnt_nxt == '0);
  end

  assign fifo_rstn   = r_rstn;
  assign dma_rstn    = r_rstn;
  assign acc_rstn    = r_rstn;
  assign acc_enable  = r_acc_enable;
  assign acc_clear   = r_acc_clear;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_cam_frame_sequencer.sv
//==============================================================================
// Module   : tb_cam_frame_sequencer
// Brief    : Directed self-checking bench for cam_frame_sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cam_frame_sequencer;

  localparam int FCNT_W = 16;

  logic              sys_clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_stop = 1'b0;
  logic [FCNT_W-1:0] num_frames = '0;
  logic              cmos_vsync = 1'b0;
  logic              fifo_rstn;
  logic              dma_rstn;
  logic              acc_rstn;
  logic              acc_enable;
  logic              acc_clear;
  logic              busy;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              timeout_err;

  int n_pass   = 0;
  int n_checks = 0;
  int n_clr    = 0;
  int n_done   = 0;
  int n_rst_lo = 0;
  int base_clr;
  int base_done;
  int base_lo;

  cam_frame_sequencer #(
    .RST_CYCLES     (16),
    .DRAIN_CYCLES   (8),
    .TIMEOUT_CYCLES (100),
    .FCNT_W         (FCNT_W)
  ) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .cmd_start   (cmd_start),
    .cmd_stop    (cmd_stop),
    .num_frames  (num_frames),
    .cmos_vsync  (cmos_vsync),
    .fifo_rstn   (fifo_rstn),
    .dma_rstn    (dma_rstn),
    .acc_rstn    (acc_rstn),
    .acc_enable  (acc_enable),
    .acc_clear   (acc_clear),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  always #5 sys_clock = ~sys_clock;

  always @(negedge sys_clock) begin
    if (reset) begin
      if (acc_clear)  n_clr++;
      if (frame_done) n_done++;
      if (!fifo_rstn) n_rst_lo++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {fifo,dma,acc rstn, acc_enable, acc_clear, busy, frame_done, timeout_err}
  function automatic logic [31:0] outs();
    return 32'({fifo_rstn, dma_rstn, acc_rstn, acc_enable, acc_clear,
                busy, frame_done, timeout_err});
  endfunction

  task automatic pulse_start(input logic [FCNT_W-1:0] nf);
    num_frames = nf;
    cmd_start  = 1'b1;
    tick(1);
    cmd_start  = 1'b0;
  endtask

  // Runs one frame from WAIT_VS: rising vsync at cycle W, the closing edge at W2.
  task automatic do_frame(input logic [FCNT_W-1:0] exp_cnt, input bit stop_mid,
                          input bit exp_busy_after);
    cmos_vsync = 1'b0;
    tick(2);
    cmos_vsync = 1'b1;
    tick(3);
    chk("clr_before", 32'({acc_clear, acc_enable}), 32'b00);
    tick(1);
    chk("clr_pulse", 32'({acc_clear, acc_enable}), 32'b11);
    tick(1);
    chk("clr_end", 32'({acc_clear, acc_enable}), 32'b01);
    cmos_vsync = 1'b0;
    tick(10);
    if (stop_mid) begin
      cmd_stop = 1'b1;
      tick(1);
      cmd_stop = 1'b0;
    end
    cmos_vsync = 1'b1;
    tick(3);
    chk("en_hold", 32'(acc_enable), 32'd1);
    tick(1);
    chk("en_drop", 32'({acc_enable, busy}), 32'b01);
    tick(6);
    chk("done_early", 32'(frame_done), 32'd0);
    tick(1);
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_cnt", 32'(frame_cnt), 32'(exp_cnt));
    cmos_vsync = 1'b0;
    tick(1);
    chk("done_end", 32'(frame_done), 32'd0);
    chk("busy_after", 32'(busy), 32'(exp_busy_after));
  endtask

  initial begin
    // Reset values, during and after reset.
    tick(3);
    chk("rst_outs", outs(), 32'hE0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b1;
    tick(2);
    chk("idle_outs", outs(), 32'hE0);

    // vsync activity without a start leaves everything idle.
    repeat (3) begin
      cmos_vsync = 1'b1;
      tick(6);
      cmos_vsync = 1'b0;
      tick(6);
    end
    chk("novs_outs", outs(), 32'hE0);
    chk("novs_cnt", 32'(frame_cnt), 32'd0);
    chk("novs_clr", 32'(n_clr), 32'd0);

    // Two-frame capture with 16-cycle soft reset.
    base_clr  = n_clr;
    base_done = n_done;
    base_lo   = n_rst_lo;
    pulse_start(16'd2);
    chk("start_outs", outs(), 32'h04);
    tick(15);
    chk("rst_hold", outs(), 32'h04);
    tick(1);
    chk("rst_release", outs(), 32'hE4);
    chk("rst_lo_len", 32'(n_rst_lo - base_lo), 32'd16);
    do_frame(16'd1, 1'b0, 1'b1);
    do_frame(16'd2, 1'b0, 1'b0);
    chk("two_clr", 32'(n_clr - base_clr), 32'd2);
    chk("two_done", 32'(n_done - base_done), 32'd2);
    chk("two_idle", outs(), 32'hE0);
    chk("two_cnt", 32'(frame_cnt), 32'd2);

    // Continuous capture, stop during frame 3 lets it complete.
    pulse_start(16'd0);
    chk("cont_cnt_clr", 32'(frame_cnt), 32'd0);
    tick(16);
    do_frame(16'd1, 1'b0, 1'b1);
    do_frame(16'd2, 1'b0, 1'b1);
    do_frame(16'd3, 1'b1, 1'b0);
    chk("cont_cnt", 32'(frame_cnt), 32'd3);

    // Stop during RESET aborts on the next cycle.
    base_done = n_done;
    pulse_start(16'd0);
    tick(4);
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    chk("rststop_outs", outs(), 32'hE0);
    chk("rststop_cnt", 32'(frame_cnt), 32'd0);
    chk("rststop_done", 32'(n_done - base_done), 32'd0);

    // Timeout: 16 reset cycles then 100 WAIT_VS cycles with no vsync.
    pulse_start(16'd0);
    tick(115);
    chk("to_before", outs(), 32'hE4);
    tick(1);
    chk("to_set", outs(), 32'hE1);
    tick(3);
    chk("to_sticky", outs(), 32'hE1);
    pulse_start(16'd0);
    chk("to_cleared", outs(), 32'h04);
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    chk("to_abort", outs(), 32'hE0);

    // Asynchronous reset in the middle of CAPTURE.
    pulse_start(16'd1);
    tick(16);
    cmos_vsync = 1'b1;
    tick(5);
    chk("cap_outs", outs(), 32'hF4);
    reset = 1'b0;
    #2;
    chk("async_outs", outs(), 32'hE0);
    cmos_vsync = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("post_rst_idle", outs(), 32'hE0);
    pulse_start(16'd1);
    tick(16);
    do_frame(16'd1, 1'b0, 1'b0);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
